// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel and the fetch-to-decode
// output register, bundled for the fetch stage and its environment.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data,
    output if_valid,
    output if_pc,
    output if_inst,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data,
    input  if_valid,
    input  if_pc,
    input  if_inst,
    output id_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues one imem request per PC,
// buffers the instruction for decode and squashes on EXE/CSR redirects.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [63:0]  next_pc,
  input  logic         redirect,
  input  logic [63:0]  redirect_pc,
  output logic [63:0]  pc,
  output logic         fetch_busy,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [63:0] pc_r;
  logic        if_valid_r;
  logic [63:0] if_pc_r;
  logic [31:0] if_inst_r;
  logic [31:0] pend_inst_r;

  logic        accept_s;
  logic        load_resp_s;
  logic        load_pend_s;
  logic        capture_pend_s;

  assign accept_s = ~if_valid_r | bus.id_ready;

  // Next-state and load decode; redirect overrides every normal transition.
  always_comb begin
    state_nxt_s    = state_r;
    load_resp_s    = 1'b0;
    load_pend_s    = 1'b0;
    capture_pend_s = 1'b0;
    if (redirect) begin
      // Track whether a squashed response is still owed by the memory.
      case (state_r)
        REQ:     state_nxt_s = bus.imem_req_ready  ? DROP : REQ;
        WAIT:    state_nxt_s = bus.imem_resp_valid ? REQ  : DROP;
        HOLD:    state_nxt_s = REQ;
        DROP:    state_nxt_s = bus.imem_resp_valid ? REQ  : DROP;
        default: state_nxt_s = REQ;
      endcase
    end else begin
      case (state_r)
        REQ: begin
          if (bus.imem_req_ready) begin
            state_nxt_s = WAIT;
          end else begin
            state_nxt_s = REQ;
          end
        end
        WAIT: begin
          if (bus.imem_resp_valid) begin
            if (accept_s) begin
              load_resp_s = 1'b1;
              state_nxt_s = REQ;
            end else begin
              capture_pend_s = 1'b1;
              state_nxt_s    = HOLD;
            end
          end else begin
            state_nxt_s = WAIT;
          end
        end
        HOLD: begin
          if (bus.id_ready) begin
            load_pend_s = 1'b1;
            state_nxt_s = REQ;
          end else begin
            state_nxt_s = HOLD;
          end
        end
        DROP: begin
          if (bus.imem_resp_valid) begin
            state_nxt_s = REQ;
          end else begin
            state_nxt_s = DROP;
          end
        end
        default: state_nxt_s = REQ;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= REQ;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Fetch PC, decode output register and the held response word.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r        <= RESET_PC;
      if_valid_r  <= 1'b0;
      if_pc_r     <= 64'h0000_0000_0000_0000;
      if_inst_r   <= NOP_INST;
      pend_inst_r <= 32'h0000_0000;
    end else if (redirect) begin
      pc_r        <= redirect_pc;
      if_valid_r  <= 1'b0;
      if_inst_r   <= NOP_INST;
      pend_inst_r <= 32'h0000_0000;
    end else begin
      if (load_resp_s) begin
        if_valid_r <= 1'b1;
        if_pc_r    <= pc_r;
        if_inst_r  <= bus.imem_resp_data;
        pc_r       <= next_pc;
      end else if (load_pend_s) begin
        if_valid_r <= 1'b1;
        if_pc_r    <= pc_r;
        if_inst_r  <= pend_inst_r;
        pc_r       <= next_pc;
      end else if (if_valid_r && bus.id_ready) begin
        if_valid_r <= 1'b0;
        if_inst_r  <= NOP_INST;
      end
      if (capture_pend_s) begin
        pend_inst_r <= bus.imem_resp_data;
      end
    end
  end

  // The loads are only decoded without redirect, so they mark fetch-complete.
  assign fetch_busy         = rst | ~(load_resp_s | load_pend_s);
  assign bus.imem_req_valid = ~rst & (state_r == REQ);
  assign bus.imem_req_addr  = pc_r;
  assign bus.if_valid       = if_valid_r;
  assign bus.if_pc          = if_pc_r;
  assign bus.if_inst        = if_inst_r;
  assign pc                 = pc_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, decode stall, redirect squashing
// and reset out of HOLD, all against hand-computed values.
module tb_fetch_unit;
  logic        clk;
  logic        rst;
  logic [63:0] next_pc;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [63:0] pc;
  logic        fetch_busy;
  int          checks;
  int          failures;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC (64'h0000_0000_0000_1000),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .next_pc     (next_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .fetch_busy  (fetch_busy),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // One uncontended fetch: REQ cycle accepted, WAIT cycle with the response.
  task automatic do_fetch(input logic [63:0] addr, input logic [31:0] data, input logic [63:0] nxt);
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b0;
    settle();
    check_eq("req_valid", {63'd0, bus.imem_req_valid}, 64'd1);
    check_eq("req_addr", bus.imem_req_addr, addr);
    check_eq("busy_req", {63'd0, fetch_busy}, 64'd1);
    tick();
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = data;
    next_pc             = nxt;
    settle();
    check_eq("wait_no_req", {63'd0, bus.imem_req_valid}, 64'd0);
    check_eq("busy_complete", {63'd0, fetch_busy}, 64'd0);
    tick();
    bus.imem_resp_valid = 1'b0;
    settle();
  endtask

  initial begin
    checks              = 0;
    failures            = 0;
    rst                 = 1'b1;
    next_pc             = 64'd0;
    redirect            = 1'b0;
    redirect_pc         = 64'd0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'd0;
    bus.id_ready        = 1'b1;
    tick();
    tick();
    check_eq("rst_req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
    check_eq("rst_busy", {63'd0, fetch_busy}, 64'd1);
    check_eq("rst_if_valid", {63'd0, bus.if_valid}, 64'd0);
    check_eq("rst_if_pc", bus.if_pc, 64'd0);
    check_eq("rst_if_inst", {32'd0, bus.if_inst}, 64'h13);
    check_eq("rst_pc", pc, 64'h1000);
    rst = 1'b0;

    // Stream three instructions, one every two cycles.
    for (int k = 0; k < 3; k++) begin
      do_fetch(64'h1000 + 64'(4 * k), 32'hA000_0000 + 32'(k), 64'h1004 + 64'(4 * k));
      check_eq("stream_if_valid", {63'd0, bus.if_valid}, 64'd1);
      check_eq("stream_if_pc", bus.if_pc, 64'h1000 + 64'(4 * k));
      check_eq("stream_if_inst", {32'd0, bus.if_inst}, {32'd0, 32'hA000_0000 + 32'(k)});
      check_eq("stream_pc", pc, 64'h1004 + 64'(4 * k));
    end

    // Decode stall: response arrives while decode refuses the output register.
    bus.id_ready       = 1'b0;
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'hDEAD_BEEF;
    next_pc             = 64'h1010;
    settle();
    check_eq("stall_busy", {63'd0, fetch_busy}, 64'd1);
    tick();
    bus.imem_resp_valid = 1'b0;
    bus.imem_req_ready  = 1'b1;
    settle();
    check_eq("hold_no_req", {63'd0, bus.imem_req_valid}, 64'd0);
    check_eq("hold_if_inst", {32'd0, bus.if_inst}, 64'hA000_0002);
    check_eq("hold_if_valid", {63'd0, bus.if_valid}, 64'd1);
    tick();
    check_eq("hold_no_req2", {63'd0, bus.imem_req_valid}, 64'd0);
    bus.id_ready = 1'b1;
    settle();
    check_eq("hold_complete", {63'd0, fetch_busy}, 64'd0);
    tick();
    check_eq("hold_out_inst", {32'd0, bus.if_inst}, 64'hDEAD_BEEF);
    check_eq("hold_out_pc", bus.if_pc, 64'h100C);
    check_eq("hold_next_addr", bus.imem_req_addr, 64'h1010);
    check_eq("hold_next_req", {63'd0, bus.imem_req_valid}, 64'd1);

    // Redirect one cycle after acceptance; stale response three cycles later.
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    redirect           = 1'b1;
    redirect_pc        = 64'h2000;
    settle();
    check_eq("redir_busy", {63'd0, fetch_busy}, 64'd1);
    tick();
    redirect = 1'b0;
    settle();
    check_eq("drop_no_req", {63'd0, bus.imem_req_valid}, 64'd0);
    check_eq("drop_pc", pc, 64'h2000);
    check_eq("drop_if_valid", {63'd0, bus.if_valid}, 64'd0);
    tick();
    check_eq("drop_no_req2", {63'd0, bus.imem_req_valid}, 64'd0);
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'h1111_1111;
    settle();
    check_eq("drop_busy", {63'd0, fetch_busy}, 64'd1);
    tick();
    bus.imem_resp_valid = 1'b0;
    settle();
    check_eq("stale_if_valid", {63'd0, bus.if_valid}, 64'd0);
    check_eq("stale_if_inst", {32'd0, bus.if_inst}, 64'h13);

    // Response and redirect together in WAIT.
    bus.imem_req_ready = 1'b1;
    settle();
    check_eq("redir_req_addr", bus.imem_req_addr, 64'h2000);
    tick();
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'h2222_2222;
    next_pc             = 64'h2004;
    redirect            = 1'b1;
    redirect_pc         = 64'h3000;
    settle();
    check_eq("both_busy", {63'd0, fetch_busy}, 64'd1);
    tick();
    bus.imem_resp_valid = 1'b0;
    redirect            = 1'b0;
    settle();
    check_eq("both_if_valid", {63'd0, bus.if_valid}, 64'd0);
    check_eq("both_req_valid", {63'd0, bus.imem_req_valid}, 64'd1);
    check_eq("both_req_addr", bus.imem_req_addr, 64'h3000);

    // Acceptance and redirect in the same REQ cycle.
    bus.imem_req_ready = 1'b1;
    redirect           = 1'b1;
    redirect_pc        = 64'h4000;
    tick();
    redirect = 1'b0;
    settle();
    check_eq("acc_drop_no_req", {63'd0, bus.imem_req_valid}, 64'd0);
    check_eq("acc_drop_pc", pc, 64'h4000);
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'h3333_3333;
    tick();
    bus.imem_resp_valid = 1'b0;
    settle();
    check_eq("acc_drop_if_valid", {63'd0, bus.if_valid}, 64'd0);
    do_fetch(64'h4000, 32'h4444_4444, 64'h4004);
    check_eq("acc_after_inst", {32'd0, bus.if_inst}, 64'h4444_4444);
    check_eq("acc_after_pc", bus.if_pc, 64'h4000);

    // Reset while holding a response for a stalled decode.
    bus.id_ready       = 1'b0;
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'h5555_5555;
    next_pc             = 64'h4008;
    tick();
    bus.imem_resp_valid = 1'b0;
    settle();
    check_eq("rhold_no_req", {63'd0, bus.imem_req_valid}, 64'd0);
    rst = 1'b1;
    tick();
    check_eq("rhold_if_valid", {63'd0, bus.if_valid}, 64'd0);
    check_eq("rhold_if_inst", {32'd0, bus.if_inst}, 64'h13);
    check_eq("rhold_pc", pc, 64'h1000);
    check_eq("rhold_req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
    check_eq("rhold_busy", {63'd0, fetch_busy}, 64'd1);
    rst          = 1'b0;
    bus.id_ready = 1'b1;
    do_fetch(64'h1000, 32'h6666_6666, 64'h1004);
    check_eq("rhold_after_inst", {32'd0, bus.if_inst}, 64'h6666_6666);
    check_eq("rhold_after_valid", {63'd0, bus.if_valid}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
